mc_control_unit: RTL and testbench
==================================

# mc_control_unit

Multi-cycle, FSM-based control unit for the RISC-V teaching core.
- Generation after the single-cycle combinational decoder: drives the same datapath control signals, but sequences each instruction over several clock cycles.
- Adds multi-cycle multiply (R-type, funct7 = 0000001) with a parametrised latency.
- Sits between the instruction register and the multi-cycle datapath: ALU, register file, data memory and the separate multiplier unit.

## Interface
Parameters:
- MUL_LATENCY, 4: cycles spent in MUL_WAIT; legal range 1..16.
- ENABLE_MUL, 1: when 0, MUL encodings are decoded as illegal.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  instruction opcode; valid from the cycle after ir_write.
- funct7  in  7  instruction funct7; valid with opcode.
- pc_write  out  1  PC <= PC+4 (FETCH only).
- ir_write  out  1  load instruction register.
- alu_src  out  1  ALU operand B: 0 = register, 1 = immediate.
- alu_op  out  2  00 add, 01 sub, 10 R-type.
- branch  out  1  branch-compare enable.
- jump  out  1  jump enable.
- mem_read  out  1  data-memory read.
- mem_write  out  1  data-memory write.
- mem_2_reg  out  1  write-back source is memory.
- mul_start  out  1  one-cycle multiplier start pulse.
- mul_sel  out  1  write-back source is multiplier result.
- reg_write  out  1  register-file write.
- instr_done  out  1  pulse in the last cycle of every instruction.
- illegal_instr  out  1  pulse on an unsupported opcode.

## Operation
- States: FETCH, DECODE, EXEC, MUL_WAIT, MEM, WB.
- Reset:
  - rst high → state = FETCH, op_q = 0, counter = 0.
  - While rst is high, every output is forced to 0.
- FETCH: ir_write = 1, pc_write = 1 → DECODE.
- DECODE:
  - Latch opcode/funct7 into op_q/f7_q.
  - Opcode class:
    - MUL (0110011 with funct7 = 0000001, and ENABLE_MUL = 1): mul_start = 1, counter <= MUL_LATENCY-1 → MUL_WAIT.
    - ALU_R (0110011), ALU_I (0010011), LOAD (0000011), STORE (0100011), BRANCH (1100011), JAL (1101111) → EXEC.
    - Anything else: illegal_instr = 1, instr_done = 1 → FETCH.
- EXEC, values by op_q:
  - R: alu_src 0, alu_op 10 → WB.
  - I: alu_src 1, alu_op 00 → WB.
  - LOAD/STORE: alu_src 1, alu_op 00 → MEM.
  - BRANCH: alu_src 0, alu_op 01, branch 1, instr_done 1 → FETCH.
  - JAL: jump 1, alu_op 10, instr_done 1 → FETCH.
- MEM (alu_src 1, alu_op 00 held):
  - LOAD: mem_read 1 → WB.
  - STORE: mem_write 1, instr_done 1 → FETCH.
- MUL_WAIT:
  - counter == 0 → WB.
  - Otherwise counter decrements.
- WB:
  - Always: reg_write 1, instr_done 1 → FETCH.
  - LOAD: also mem_2_reg 1.
  - MUL: also mul_sel 1.
- Any output not listed for a state is driven 0. No X outputs.

## Timing
- Outputs are Moore: decoded from state and op_q only, except in DECODE, where they decode directly from the opcode/funct7 inputs.
- Cycles per instruction:
  - BRANCH/JAL: 3.
  - R, I, STORE: 4.
  - LOAD: 5.
  - MUL: 3 + MUL_LATENCY.
  - Illegal: 2.
- mul_start is high for exactly one cycle (DECODE). MUL_WAIT lasts exactly MUL_LATENCY cycles.
- instr_done is high for exactly one cycle per instruction, and is never asserted in FETCH.
- rst asserted in any state, including mid-MUL_WAIT: outputs are 0 in that same cycle, and the state is FETCH on the following edge. The counter is cleared; no stale mul_sel/reg_write may follow.
- Opcode changes after DECODE are ignored until the next DECODE.

## Structure
- Shared package ctrl_pkg holds:
  - Opcode constants.
  - MUL funct7 constant.
  - ALUOp constants (ADD 00, SUB 01, R_TYPE 10).
  - State encoding, 3-bit.
- One natural sub-module, mc_ctrl_decode: combinational classifier from (opcode, funct7, ENABLE_MUL) to a one-hot instruction class {R, I, LOAD, STORE, BRANCH, JAL, MUL, ILLEGAL}.
- Top level keeps the FSM, the op_q/f7_q latches and the $clog2(MUL_LATENCY+1)-bit counter.

## Test plan
- Reset then add (0110011/0000000): ir_write+pc_write in cycle 1; alu_op = 10 in cycle 3; reg_write+instr_done in cycle 4; back to FETCH.
- LOAD then STORE:
  - LOAD: mem_read in cycle 4; reg_write+mem_2_reg in cycle 5.
  - STORE: mem_write+instr_done in cycle 4; reg_write never asserted.
- MUL with MUL_LATENCY = 4: mul_start in cycle 2, no reg_write in cycles 3–6, reg_write+mul_sel+instr_done in cycle 7. Repeat with MUL_LATENCY = 1: WB in cycle 4.
- BRANCH (1100011): branch=1, alu_op=01, instr_done in cycle 3. Opcode 1111111: illegal_instr+instr_done in cycle 2. ENABLE_MUL = 0 with a MUL encoding: flagged illegal.
- rst pulsed during the 2nd MUL_WAIT cycle: all outputs 0 that cycle; next cycle is FETCH (ir_write = 1); no later mul_sel/reg_write.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared constants for the multi-cycle RISC-V control unit: opcodes,
// ALUOp encodings, FSM state encoding and instruction-class bit indices.
package ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_MUL     = 7'b0000001;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_R_TYPE = 2'b10;

    localparam logic [2:0] ST_FETCH    = 3'd0;
    localparam logic [2:0] ST_DECODE   = 3'd1;
    localparam logic [2:0] ST_EXEC     = 3'd2;
    localparam logic [2:0] ST_MUL_WAIT = 3'd3;
    localparam logic [2:0] ST_MEM      = 3'd4;
    localparam logic [2:0] ST_WB       = 3'd5;

    // Bit positions inside the one-hot instruction class vector
    localparam int CLS_R       = 0;
    localparam int CLS_I       = 1;
    localparam int CLS_LOAD    = 2;
    localparam int CLS_STORE   = 3;
    localparam int CLS_BRANCH  = 4;
    localparam int CLS_JAL     = 5;
    localparam int CLS_MUL     = 6;
    localparam int CLS_ILLEGAL = 7;
    localparam int CLS_W       = 8;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational classifier: maps opcode/funct7 to a one-hot instruction class.
module mc_ctrl_decode
    import ctrl_pkg::*;
#(
    parameter bit ENABLE_MUL = 1'b1
) (
    input  logic [6:0]       i_opcode,
    input  logic [6:0]       i_funct7,
    output logic [CLS_W-1:0] o_class
);

    // Unsupported opcodes, and MUL when the multiplier is absent, fall to ILLEGAL
    always_comb begin
        o_class = '0;
        case (i_opcode)
            OPC_R: begin
                if (i_funct7 == F7_MUL) begin
                    if (ENABLE_MUL) begin
                        o_class[CLS_MUL] = 1'b1;
                    end else begin
                        o_class[CLS_ILLEGAL] = 1'b1;
                    end
                end else begin
                    o_class[CLS_R] = 1'b1;
                end
            end
            OPC_I:      o_class[CLS_I]      = 1'b1;
            OPC_LOAD:   o_class[CLS_LOAD]   = 1'b1;
            OPC_STORE:  o_class[CLS_STORE]  = 1'b1;
            OPC_BRANCH: o_class[CLS_BRANCH] = 1'b1;
            OPC_JAL:    o_class[CLS_JAL]    = 1'b1;
            default:    o_class[CLS_ILLEGAL] = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle FSM control unit: sequences FETCH/DECODE/EXEC/MUL_WAIT/MEM/WB
// and drives the datapath control lines (Moore, except during DECODE).
module mc_control_unit
    import ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = 4,
    parameter int ENABLE_MUL  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [6:0] funct7,
    output logic       pc_write,
    output logic       ir_write,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       branch,
    output logic       jump,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_2_reg,
    output logic       mul_start,
    output logic       mul_sel,
    output logic       reg_write,
    output logic       instr_done,
    output logic       illegal_instr
);

    localparam int CNT_W = $clog2(MUL_LATENCY + 1);

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [6:0]       r_op_q;
    logic [6:0]       r_f7_q;
    logic [CNT_W-1:0] r_cnt;
    logic [6:0]       w_dec_opc;
    logic [6:0]       w_dec_f7;
    logic [CLS_W-1:0] w_class;

    logic       w_pc_write, w_ir_write, w_alu_src, w_branch, w_jump;
    logic       w_mem_read, w_mem_write, w_mem_2_reg, w_mul_start, w_mul_sel;
    logic       w_reg_write, w_instr_done, w_illegal;
    logic [1:0] w_alu_op;

    // One classifier serves both the live inputs (DECODE) and the latched instruction
    assign w_dec_opc = (r_state == ST_DECODE) ? opcode : r_op_q;
    assign w_dec_f7  = (r_state == ST_DECODE) ? funct7 : r_f7_q;

    mc_ctrl_decode #(
        .ENABLE_MUL (ENABLE_MUL != 0)
    ) u_decode (
        .i_opcode (w_dec_opc),
        .i_funct7 (w_dec_f7),
        .o_class  (w_class)
    );

    // State register, instruction latches and multiply wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_op_q  <= 7'd0;
            r_f7_q  <= 7'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_DECODE) begin
                r_op_q <= opcode;
                r_f7_q <= funct7;
            end
            if ((r_state == ST_DECODE) && w_class[CLS_MUL]) begin
                r_cnt <= CNT_W'(MUL_LATENCY - 1);
            end else if ((r_state == ST_MUL_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Next-state and per-state control decode
    always_comb begin
        w_next_state = r_state;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_alu_src    = 1'b0;
        w_alu_op     = ALUOP_ADD;
        w_branch     = 1'b0;
        w_jump       = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_2_reg  = 1'b0;
        w_mul_start  = 1'b0;
        w_mul_sel    = 1'b0;
        w_reg_write  = 1'b0;
        w_instr_done = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_ir_write   = 1'b1;
                w_pc_write   = 1'b1;
                w_next_state = ST_DECODE;
            end
            ST_DECODE: begin
                if (w_class[CLS_MUL]) begin
                    w_mul_start  = 1'b1;
                    w_next_state = ST_MUL_WAIT;
                end else if (w_class[CLS_ILLEGAL]) begin
                    w_illegal    = 1'b1;
                    w_instr_done = 1'b1;
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_class[CLS_R]) begin
                    w_alu_op     = ALUOP_R_TYPE;
                    w_next_state = ST_WB;
                end else if (w_class[CLS_I]) begin
                    w_alu_src    = 1'b1;
                    w_next_state = ST_WB;
                end else if (w_class[CLS_LOAD] || w_class[CLS_STORE]) begin
                    w_alu_src    = 1'b1;
                    w_next_state = ST_MEM;
                end else if (w_class[CLS_BRANCH]) begin
                    w_alu_op     = ALUOP_SUB;
                    w_branch     = 1'b1;
                    w_instr_done = 1'b1;
                    w_next_state = ST_FETCH;
                end else if (w_class[CLS_JAL]) begin
                    w_jump       = 1'b1;
                    w_alu_op     = ALUOP_R_TYPE;
                    w_instr_done = 1'b1;
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_MEM: begin
                w_alu_src = 1'b1;
                if (w_class[CLS_LOAD]) begin
                    w_mem_read   = 1'b1;
                    w_next_state = ST_WB;
                end else begin
                    w_mem_write  = 1'b1;
                    w_instr_done = 1'b1;
                    w_next_state = ST_FETCH;
                end
            end
            ST_MUL_WAIT: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_WB;
                end else begin
                    w_next_state = ST_MUL_WAIT;
                end
            end
            ST_WB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_mem_2_reg  = w_class[CLS_LOAD];
                w_mul_sel    = w_class[CLS_MUL];
                w_next_state = ST_FETCH;
            end
            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

    // Reset blanks every output in the same cycle it is asserted
    assign pc_write      = w_pc_write   & ~rst;
    assign ir_write      = w_ir_write   & ~rst;
    assign alu_src       = w_alu_src    & ~rst;
    assign alu_op        = w_alu_op     & {2{~rst}};
    assign branch        = w_branch     & ~rst;
    assign jump          = w_jump       & ~rst;
    assign mem_read      = w_mem_read   & ~rst;
    assign mem_write     = w_mem_write  & ~rst;
    assign mem_2_reg     = w_mem_2_reg  & ~rst;
    assign mul_start     = w_mul_start  & ~rst;
    assign mul_sel       = w_mul_sel    & ~rst;
    assign reg_write     = w_reg_write  & ~rst;
    assign instr_done    = w_instr_done & ~rst;
    assign illegal_instr = w_illegal    & ~rst;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: three instances (MUL latency 4, latency 1,
// multiplier disabled) share stimulus; outputs are packed and compared per cycle.
module tb_mc_control_unit;
    import ctrl_pkg::*;

    // Packed output layout: {pc,ir,src,alu_op[1:0],br,j,mr,mw,m2r,ms,msel,rw,done,ill}
    localparam logic [14:0] B_PC    = 15'h4000;
    localparam logic [14:0] B_IR    = 15'h2000;
    localparam logic [14:0] B_SRC   = 15'h1000;
    localparam logic [14:0] AOP_R   = 15'h0800;
    localparam logic [14:0] AOP_SUB = 15'h0400;
    localparam logic [14:0] B_BR    = 15'h0200;
    localparam logic [14:0] B_J     = 15'h0100;
    localparam logic [14:0] B_MR    = 15'h0080;
    localparam logic [14:0] B_MW    = 15'h0040;
    localparam logic [14:0] B_M2R   = 15'h0020;
    localparam logic [14:0] B_MS    = 15'h0010;
    localparam logic [14:0] B_MSEL  = 15'h0008;
    localparam logic [14:0] B_RW    = 15'h0004;
    localparam logic [14:0] B_DONE  = 15'h0002;
    localparam logic [14:0] B_ILL   = 15'h0001;
    localparam logic [14:0] V_FETCH = B_PC | B_IR;
    localparam logic [14:0] V_ZERO  = 15'h0000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [6:0] funct7 = 7'd0;

    logic       pc_w [3], ir_w [3], src_w [3], br_w [3], j_w [3], mr_w [3], mw_w [3];
    logic       m2r_w [3], ms_w [3], msel_w [3], rw_w [3], done_w [3], ill_w [3];
    logic [1:0] aop_w [3];
    logic [14:0] v [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mc_control_unit #(.MUL_LATENCY(4), .ENABLE_MUL(1)) dut_l4 (
        .clk(clk), .rst(rst), .opcode(opcode), .funct7(funct7),
        .pc_write(pc_w[0]), .ir_write(ir_w[0]), .alu_src(src_w[0]), .alu_op(aop_w[0]),
        .branch(br_w[0]), .jump(j_w[0]), .mem_read(mr_w[0]), .mem_write(mw_w[0]),
        .mem_2_reg(m2r_w[0]), .mul_start(ms_w[0]), .mul_sel(msel_w[0]),
        .reg_write(rw_w[0]), .instr_done(done_w[0]), .illegal_instr(ill_w[0]));

    mc_control_unit #(.MUL_LATENCY(1), .ENABLE_MUL(1)) dut_l1 (
        .clk(clk), .rst(rst), .opcode(opcode), .funct7(funct7),
        .pc_write(pc_w[1]), .ir_write(ir_w[1]), .alu_src(src_w[1]), .alu_op(aop_w[1]),
        .branch(br_w[1]), .jump(j_w[1]), .mem_read(mr_w[1]), .mem_write(mw_w[1]),
        .mem_2_reg(m2r_w[1]), .mul_start(ms_w[1]), .mul_sel(msel_w[1]),
        .reg_write(rw_w[1]), .instr_done(done_w[1]), .illegal_instr(ill_w[1]));

    mc_control_unit #(.MUL_LATENCY(4), .ENABLE_MUL(0)) dut_nomul (
        .clk(clk), .rst(rst), .opcode(opcode), .funct7(funct7),
        .pc_write(pc_w[2]), .ir_write(ir_w[2]), .alu_src(src_w[2]), .alu_op(aop_w[2]),
        .branch(br_w[2]), .jump(j_w[2]), .mem_read(mr_w[2]), .mem_write(mw_w[2]),
        .mem_2_reg(m2r_w[2]), .mul_start(ms_w[2]), .mul_sel(msel_w[2]),
        .reg_write(rw_w[2]), .instr_done(done_w[2]), .illegal_instr(ill_w[2]));

    for (genvar k = 0; k < 3; k++) begin : g_pack
        assign v[k] = {pc_w[k], ir_w[k], src_w[k], aop_w[k], br_w[k], j_w[k], mr_w[k],
                       mw_w[k], m2r_w[k], ms_w[k], msel_w[k], rw_w[k], done_w[k], ill_w[k]};
    end

    task automatic check_eq(input string tag, input logic [14:0] act, input logic [14:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, act, exp);
        end
    endtask

    // Reset for one cycle with the given instruction presented; returns sampling cycle 1 (FETCH)
    task automatic start_instr(input logic [6:0] opc, input logic [6:0] f7);
        @(negedge clk);
        rst    = 1'b1;
        opcode = opc;
        funct7 = f7;
        #1;
        check_eq("rst_l4", v[0], V_ZERO);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        // ADD: opcode scrambled after DECODE must be ignored
        start_instr(OPC_R, 7'b0000000);
        check_eq("add_c1", v[0], V_FETCH);
        next_cycle(); check_eq("add_c2", v[0], V_ZERO);
        next_cycle(); check_eq("add_c3", v[0], AOP_R);
        opcode = 7'b1111111;
        next_cycle(); check_eq("add_c4", v[0], B_RW | B_DONE);
        next_cycle(); check_eq("add_c5", v[0], V_FETCH);

        // I-type
        start_instr(OPC_I, 7'b0000000);
        next_cycle();
        next_cycle(); check_eq("addi_c3", v[0], B_SRC);
        next_cycle(); check_eq("addi_c4", v[0], B_RW | B_DONE);

        // LOAD
        start_instr(OPC_LOAD, 7'b0000000);
        check_eq("ld_c1", v[0], V_FETCH);
        next_cycle(); check_eq("ld_c2", v[0], V_ZERO);
        next_cycle(); check_eq("ld_c3", v[0], B_SRC);
        next_cycle(); check_eq("ld_c4", v[0], B_SRC | B_MR);
        next_cycle(); check_eq("ld_c5", v[0], B_RW | B_M2R | B_DONE);
        next_cycle(); check_eq("ld_c6", v[0], V_FETCH);

        // STORE
        start_instr(OPC_STORE, 7'b0000000);
        next_cycle(); check_eq("st_c2", v[0], V_ZERO);
        next_cycle(); check_eq("st_c3", v[0], B_SRC);
        next_cycle(); check_eq("st_c4", v[0], B_SRC | B_MW | B_DONE);
        next_cycle(); check_eq("st_c5", v[0], V_FETCH);

        // MUL on all three instances
        start_instr(OPC_R, F7_MUL);
        check_eq("mul4_c1", v[0], V_FETCH);
        check_eq("mul1_c1", v[1], V_FETCH);
        next_cycle();
        check_eq("mul4_c2", v[0], B_MS);
        check_eq("mul1_c2", v[1], B_MS);
        check_eq("nomul_c2", v[2], B_ILL | B_DONE);
        next_cycle();
        check_eq("mul4_c3", v[0], V_ZERO);
        check_eq("mul1_c3", v[1], V_ZERO);
        check_eq("nomul_c3", v[2], V_FETCH);
        next_cycle();
        check_eq("mul4_c4", v[0], V_ZERO);
        check_eq("mul1_c4", v[1], B_RW | B_MSEL | B_DONE);
        next_cycle();
        check_eq("mul4_c5", v[0], V_ZERO);
        check_eq("mul1_c5", v[1], V_FETCH);
        next_cycle(); check_eq("mul4_c6", v[0], V_ZERO);
        next_cycle(); check_eq("mul4_c7", v[0], B_RW | B_MSEL | B_DONE);
        next_cycle(); check_eq("mul4_c8", v[0], V_FETCH);

        // BRANCH
        start_instr(OPC_BRANCH, 7'b0000000);
        next_cycle(); check_eq("br_c2", v[0], V_ZERO);
        next_cycle(); check_eq("br_c3", v[0], AOP_SUB | B_BR | B_DONE);
        next_cycle(); check_eq("br_c4", v[0], V_FETCH);

        // JAL
        start_instr(OPC_JAL, 7'b0000000);
        next_cycle();
        next_cycle(); check_eq("jal_c3", v[0], B_J | AOP_R | B_DONE);
        next_cycle(); check_eq("jal_c4", v[0], V_FETCH);

        // Illegal opcode
        start_instr(7'b1111111, 7'b0000000);
        next_cycle(); check_eq("ill_c2", v[0], B_ILL | B_DONE);
        next_cycle(); check_eq("ill_c3", v[0], V_FETCH);

        // Reset during the second MUL_WAIT cycle, then a BRANCH
        start_instr(OPC_R, F7_MUL);
        next_cycle(); check_eq("rmul_c2", v[0], B_MS);
        next_cycle(); check_eq("rmul_c3", v[0], V_ZERO);
        @(negedge clk);
        rst    = 1'b1;
        opcode = OPC_BRANCH;
        funct7 = 7'b0000000;
        #1;
        check_eq("rmul_rst", v[0], V_ZERO);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rmul_fetch", v[0], V_FETCH);
        next_cycle(); check_eq("rmul_dec", v[0], V_ZERO);
        next_cycle(); check_eq("rmul_exec", v[0], AOP_SUB | B_BR | B_DONE);
        next_cycle(); check_eq("rmul_after", v[0], V_FETCH);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
